// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Sequential shift-and-add unsigned multiplier. Operands are captured on an
//   accepted start (IDLE only), one partial product is folded in per clock for
//   N clocks, then the 2N-bit product is registered together with a one-cycle
//   done pulse. The product holds until the next result or reset.
//
// Parameters
//   N             operand width in bits (N >= 2); product is 2N bits
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   start         request; sampled only in IDLE
//   multiplicand  operand A (unsigned), captured on accepted start
//   multiplier    operand B (unsigned), captured on accepted start
//   busy          high while iterating (exactly N cycles)
//   done          one-cycle pulse, product valid
//   product       A*B, held from done until the next result
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplr_q,  mplr_d;
  logic [N:0]     acc_q,   acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;
  logic [2*N-1:0] product_q, product_d;

  logic [N:0]     sum;
  logic [2*N:0]   shifted;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    count_d   = count_q;
    done_d    = 1'b0;
    product_d = product_q;

    // Partial product: carry out of the add lands in acc[N] and is shifted
    // down into the top of the low N bits on the same edge.
    if (mplr_q[0]) begin
      sum = {1'b0, acc_q[N-1:0]} + {1'b0, mcand_q};
    end else begin
      sum = acc_q;
    end
    shifted = {sum, mplr_q} >> 1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = multiplicand;
          mplr_d  = multiplier;
          acc_d   = '0;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        {acc_d, mplr_d} = shifted;
        count_d         = count_q + 1'b1;
        if (count_q == CW'(N - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        product_d = {acc_q[N-1:0], mplr_q};
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//   Directed vector table plus hand-written sequences for held start, start
//   during RUN, reset during RUN and an exhaustive sweep of all operand pairs.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

  localparam int unsigned N = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int checks;
  int errors;

  seq_multiplier #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operation with a single-cycle start pulse. If inject is set, a second
  // start with other operands is pulsed during RUN and must be ignored.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp, input logic [2*N-1:0] prev,
                        input bit inject);
    int edges;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);            // accepting edge
    #1;
    start        = 1'b0;
    multiplicand = ~a;         // operands may change after acceptance
    multiplier   = ~b;
    edges    = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (edges < 20) begin
      if (busy) busy_cnt++;
      if (busy && !done && product !== prev) begin
        check("product_hold_run", product, prev);
      end
      if (inject && edges == 1) begin
        start        = 1'b1;
        multiplicand = 4'd2;
        multiplier   = 4'd2;
      end else if (inject && edges == 2) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
      if (busy && done) check("busy_done_overlap", 1, 0);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    check("done_latency", edges, 5);
    check("busy_cycles", busy_cnt, N);
    check("product", product, exp);
    @(posedge clk);
    #1;
    check("done_pulse_width", done, 0);
    check("product_hold_idle", product, exp);
  endtask

  initial begin
    logic [2*N-1:0] last;
    int done_edges[$];
    logic [2*N-1:0] done_prods[$];

    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;

    vecs[0] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[1] = '{a: 4'd13, b: 4'd11, p: 8'h8F};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'h00};
    vecs[3] = '{a: 4'd7,  b: 4'd0,  p: 8'h00};
    vecs[4] = '{a: 4'd1,  b: 4'd1,  p: 8'h01};
    vecs[5] = '{a: 4'd8,  b: 4'd2,  p: 8'h10};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    last = '0;
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, last, 1'b0);
      last = vecs[i].p;
    end

    // Start held high: (3,5) then (6,7), done every N+2 edges.
    @(negedge clk);
    start = 1'b1;
    multiplicand = 4'd3;
    multiplier   = 4'd5;
    @(posedge clk);
    #1;
    multiplicand = 4'd6;
    multiplier   = 4'd7;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_edges.push_back(k);
        done_prods.push_back(product);
      end
      if (k == 11) start = 1'b0;
    end
    check("held_done_count", done_edges.size(), 2);
    if (done_edges.size() == 2) begin
      check("held_done_edge0", done_edges[0], 5);
      check("held_done_edge1", done_edges[1], 11);
      check("held_product0", done_prods[0], 15);
      check("held_product1", done_prods[1], 42);
    end
    repeat (8) @(posedge clk);   // let any third accepted op drain
    #1;
    last = product;

    // Start pulsed mid-RUN with new operands must be ignored.
    run_op(4'd9, 4'd9, 8'd81, last, 1'b1);
    repeat (6) begin
      @(posedge clk);
      #1;
      check("no_spurious_done", done, 0);
    end
    check("product_hold_long", product, 81);

    // Reset during the second RUN cycle.
    @(negedge clk);
    start = 1'b1;
    multiplicand = 4'd5;
    multiplier   = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("rst_no_done", done, 0);
    end
    run_op(4'd2, 4'd3, 8'd6, 8'd0, 1'b0);

    // Exhaustive sweep.
    last = 8'd6;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [2*N-1:0] expv;
        expv = 8'(a * b);
        run_op(4'(a), 4'(b), expv, last, 1'b0);
        last = expv;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
